// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multi-cycle sequencer and the processor datapath.
// Latency: n/a (wires only).
// Backpressure: data memory stalls the sequencer by holding mem_ack low.
//
// Ports / signals:
//   instr        instruction word at the current PC (datapath -> sequencer)
//   eq           readData1 == readData2 from the register file
//   mem_ack      data memory has completed the request
//   ir_write, pc_write, pc_src, reg_write, reg_dst, wb_src, alu_sel,
//   alu_src_imm, imm_zext, mem_req, mem_we, halted, illegal, retired
//                control strobes and status (sequencer -> datapath)
// master = sequencer side, slave = datapath side.
interface mc_control_fsm_if #(
  parameter int RETIRE_W = 32
);
  logic [31:0]         instr;
  logic                eq;
  logic                mem_ack;
  logic                ir_write;
  logic                pc_write;
  logic [1:0]          pc_src;
  logic                reg_write;
  logic [1:0]          reg_dst;
  logic [1:0]          wb_src;
  logic [2:0]          alu_sel;
  logic                alu_src_imm;
  logic                imm_zext;
  logic                mem_req;
  logic                mem_we;
  logic                halted;
  logic                illegal;
  logic [RETIRE_W-1:0] retired;

  modport master (
    input  instr, eq, mem_ack,
    output ir_write, pc_write, pc_src, reg_write, reg_dst, wb_src, alu_sel,
           alu_src_imm, imm_zext, mem_req, mem_we, halted, illegal, retired
  );

  modport slave (
    output instr, eq, mem_ack,
    input  ir_write, pc_write, pc_src, reg_write, reg_dst, wb_src, alu_sel,
           alu_src_imm, imm_zext, mem_req, mem_we, halted, illegal, retired
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB/HALT, Moore strobes.
// Latency: J/JAL/JR/illegal 2, branches 3, ALU ops 4, SW 4+w, LW 5+w cycles.
// Backpressure: MEM holds with mem_req high until mem_ack is sampled high.
//
// Ports:
//   clk  - single clock, posedge
//   rst  - asynchronous active-high reset; forces every output to 0 while high
//   bus  - mc_control_fsm_if.master: instr/eq/mem_ack in, control strobes out
module mc_control_fsm #(
  parameter int RETIRE_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  mc_control_fsm_if.master  bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_ANDI  = 6'd36;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_HALT  = 6'd63;
  localparam logic [5:0] FN_JR    = 6'd8;

  state_t              state_q, state_d;
  logic [5:0]          op_q, op_d;
  logic [5:0]          funct_q, funct_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;

  // Only opcode and funct are needed here; the rest of the word feeds the datapath.
  logic unused_instr_bits;
  assign unused_instr_bits = &{1'b0, bus.instr[25:6]};

  // R-type funct -> ALU operation
  logic       r_ok;
  logic [2:0] r_alu;
  always_comb begin
    r_ok  = 1'b1;
    r_alu = 3'b000;
    case (funct_q)
      6'd32:   r_alu = 3'b000;
      6'd24:   r_alu = 3'b001;
      6'd36:   r_alu = 3'b010;
      6'd37:   r_alu = 3'b011;
      6'd42:   r_alu = 3'b100;
      6'd39:   r_alu = 3'b101;
      6'd0:    r_alu = 3'b110;
      6'd2:    r_alu = 3'b111;
      default: r_ok  = 1'b0;
    endcase
  end

  logic is_r, is_jr, is_itype, is_mem, is_br, is_legal;
  assign is_r     = (op_q == OP_RTYPE) && r_ok;
  assign is_jr    = (op_q == OP_RTYPE) && (funct_q == FN_JR);
  assign is_itype = (op_q == OP_ADDI) || (op_q == OP_ANDI) || (op_q == OP_ORI);
  assign is_mem   = (op_q == OP_LW) || (op_q == OP_SW);
  assign is_br    = (op_q == OP_BEQ) || (op_q == OP_BNE);
  assign is_legal = is_r || is_jr || is_itype || is_mem || is_br ||
                    (op_q == OP_J) || (op_q == OP_JAL) || (op_q == OP_HALT);

  logic       ir_write, pc_write, reg_write, alu_src_imm, imm_zext;
  logic       mem_req, mem_we, halted, illegal, retire;
  logic [1:0] pc_src, reg_dst, wb_src;
  logic [2:0] alu_sel;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    funct_d     = funct_q;
    retire      = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'b00;
    reg_write   = 1'b0;
    reg_dst     = 2'b00;
    wb_src      = 2'b00;
    alu_sel     = 3'b000;
    alu_src_imm = 1'b0;
    imm_zext    = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    halted      = 1'b0;
    illegal     = 1'b0;

    case (state_q)
      S_FETCH: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
        op_d     = bus.instr[31:26];
        funct_d  = bus.instr[5:0];
        state_d  = S_DECODE;
      end

      S_DECODE: begin
        if (op_q == OP_HALT) begin
          state_d = S_HALT;
        end else if ((op_q == OP_J) || (op_q == OP_JAL)) begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
          if (op_q == OP_JAL) begin
            // PC already advanced in FETCH, so the link value is PC+1.
            reg_write = 1'b1;
            reg_dst   = 2'b10;
            wb_src    = 2'b10;
          end
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (is_jr) begin
          pc_write = 1'b1;
          pc_src   = 2'b11;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else if (!is_legal) begin
          // Undefined encodings retire as a NOP with a one-cycle flag.
          illegal = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        if (is_r) begin
          alu_sel = r_alu;
          state_d = S_WB;
        end else if (is_itype) begin
          alu_src_imm = 1'b1;
          imm_zext    = (op_q == OP_ANDI) || (op_q == OP_ORI);
          state_d     = S_WB;
        end else if (is_mem) begin
          alu_src_imm = 1'b1;
          state_d     = S_MEM;
        end else if (is_br) begin
          pc_src   = 2'b01;
          pc_write = (op_q == OP_BEQ) ? bus.eq : !bus.eq;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d = S_FETCH;
        end
      end

      S_MEM: begin
        // Keep the address operands selected for the whole wait.
        mem_req     = 1'b1;
        mem_we      = (op_q == OP_SW);
        alu_src_imm = 1'b1;
        if (bus.mem_ack) begin
          if (op_q == OP_SW) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        reg_write = 1'b1;
        if (is_r) begin
          reg_dst = 2'b01;
        end else if (op_q == OP_LW) begin
          wb_src = 2'b01;
        end
        retire  = 1'b1;
        state_d = S_FETCH;
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: state_d = S_FETCH;
    endcase
  end

  assign retired_d = retire ? (retired_q + RETIRE_W'(1)) : retired_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      op_q      <= 6'd0;
      funct_q   <= 6'd0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      funct_q   <= funct_d;
      retired_q <= retired_d;
    end
  end

  // Outputs are forced low during reset even though state only moves on the
  // async edge, so an in-flight memory request drops in the same cycle.
  assign bus.ir_write    = ir_write & ~rst;
  assign bus.pc_write    = pc_write & ~rst;
  assign bus.pc_src      = rst ? 2'b00 : pc_src;
  assign bus.reg_write   = reg_write & ~rst;
  assign bus.reg_dst     = rst ? 2'b00 : reg_dst;
  assign bus.wb_src      = rst ? 2'b00 : wb_src;
  assign bus.alu_sel     = rst ? 3'b000 : alu_sel;
  assign bus.alu_src_imm = alu_src_imm & ~rst;
  assign bus.imm_zext    = imm_zext & ~rst;
  assign bus.mem_req     = mem_req & ~rst;
  assign bus.mem_we      = mem_we & ~rst;
  assign bus.halted      = halted & ~rst;
  assign bus.illegal     = illegal & ~rst;
  assign bus.retired     = rst ? '0 : retired_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
module tb_mc_control_fsm;

  localparam int RW = 4;

  // Expected control vector bit masks:
  // {ir_write, pc_write, pc_src[1:0], reg_write, reg_dst[1:0], wb_src[1:0],
  //  alu_sel[2:0], alu_src_imm, imm_zext, mem_req, mem_we, halted, illegal}
  localparam logic [17:0] IRW     = 18'h20000;
  localparam logic [17:0] PCW     = 18'h10000;
  localparam logic [17:0] PS1     = 18'h04000;
  localparam logic [17:0] PS2     = 18'h08000;
  localparam logic [17:0] PS3     = 18'h0C000;
  localparam logic [17:0] RGW     = 18'h02000;
  localparam logic [17:0] RD1     = 18'h00800;
  localparam logic [17:0] RD2     = 18'h01000;
  localparam logic [17:0] WB1     = 18'h00200;
  localparam logic [17:0] WB2     = 18'h00400;
  localparam logic [17:0] ALU_SLT = 18'h00100;
  localparam logic [17:0] ALU_SRL = 18'h001C0;
  localparam logic [17:0] IMM     = 18'h00020;
  localparam logic [17:0] ZX      = 18'h00010;
  localparam logic [17:0] MRQ     = 18'h00008;
  localparam logic [17:0] MWE     = 18'h00004;
  localparam logic [17:0] HLT     = 18'h00002;
  localparam logic [17:0] ILL     = 18'h00001;
  localparam logic [17:0] NONE    = 18'h00000;

  typedef struct {
    string          nm;
    logic [17:0]    c;
    logic [RW-1:0]  r;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mc_control_fsm_if #(.RETIRE_W(RW)) bus ();

  mc_control_fsm #(.RETIRE_W(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [17:0] act;
  assign act = {bus.ir_write, bus.pc_write, bus.pc_src, bus.reg_write, bus.reg_dst,
                bus.wb_src, bus.alu_sel, bus.alu_src_imm, bus.imm_zext,
                bus.mem_req, bus.mem_we, bus.halted, bus.illegal};

  exp_t          q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [RW-1:0] ret     = '0;
  logic          done    = 1'b0;
  logic          checked = 1'b0;

  // Monitor: one expectation per cycle, compared away from the active edge.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t it;
      it = q.pop_front();
      n_tests++;
      if (act !== it.c || bus.retired !== it.r) begin
        n_fail++;
        $display("FAIL %s: ctrl=%05h retired=%0d, expected ctrl=%05h retired=%0d",
                 it.nm, act, bus.retired, it.c, it.r);
      end
    end else if (done && !checked) begin
      n_tests++;
      checked <= 1'b1;
    end
  end

  // Stimulus: drive inputs for this cycle and queue the expected outputs.
  task automatic step(input string nm, input logic [17:0] e, input logic ack, input logic eqv);
    exp_t it;
    bus.mem_ack = ack;
    bus.eq      = eqv;
    it.nm = nm;
    it.c  = e;
    it.r  = ret;
    q.push_back(it);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string nm, input logic [31:0] w);
    bus.instr = w;
    step({nm, "_fetch"}, IRW | PCW, 1'b0, 1'b0);
  endtask

  task automatic rtype(input string nm, input logic [31:0] w, input logic [17:0] alu);
    fetch(nm, w);
    step({nm, "_decode"}, NONE, 1'b0, 1'b0);
    step({nm, "_exec"}, alu, 1'b0, 1'b0);
    step({nm, "_wb"}, RGW | RD1, 1'b0, 1'b0);
    ret++;
  endtask

  task automatic itype(input string nm, input logic [5:0] op, input logic [17:0] ex);
    fetch(nm, {op, 26'h0A5_0003});
    step({nm, "_decode"}, NONE, 1'b0, 1'b0);
    step({nm, "_exec"}, ex, 1'b0, 1'b0);
    step({nm, "_wb"}, RGW, 1'b0, 1'b0);
    ret++;
  endtask

  task automatic two_cycle(input string nm, input logic [31:0] w, input logic [17:0] dec);
    fetch(nm, w);
    step({nm, "_decode"}, dec, 1'b0, 1'b0);
    ret++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    bus.instr   = 32'h0;
    bus.eq      = 1'b0;
    bus.mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step("reset", NONE, 1'b1, 1'b0);
    rst = 1'b0;

    rtype("add", 32'h012A4020, NONE);
    rtype("slt", {6'd0, 20'h4A402, 6'd42}, ALU_SLT);
    rtype("srl", {6'd0, 20'h00841, 6'd2}, ALU_SRL);

    // LW with 3 wait cycles; an early ack in EXEC must be ignored.
    fetch("lw", {6'd35, 26'h1230010});
    step("lw_decode", NONE, 1'b0, 1'b0);
    step("lw_exec", IMM, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("lw_mem_wait", MRQ | IMM, 1'b0, 1'b0);
    step("lw_mem_ack", MRQ | IMM, 1'b1, 1'b0);
    step("lw_wb", RGW | WB1, 1'b0, 1'b0);
    ret++;

    // SW with ack in the first MEM cycle.
    fetch("sw", {6'd43, 26'h1230004});
    step("sw_decode", NONE, 1'b0, 1'b0);
    step("sw_exec", IMM, 1'b0, 1'b0);
    step("sw_mem_ack", MRQ | MWE | IMM, 1'b1, 1'b0);
    ret++;

    fetch("beq", {6'd4, 26'h0000005});
    step("beq_decode", NONE, 1'b0, 1'b1);
    step("beq_exec", PCW | PS1, 1'b0, 1'b1);
    ret++;

    fetch("bne", {6'd5, 26'h0000005});
    step("bne_decode", NONE, 1'b0, 1'b1);
    step("bne_exec", PS1, 1'b0, 1'b1);
    ret++;

    two_cycle("jal", {6'd3, 26'h0000040}, PCW | PS2 | RGW | RD2 | WB2);
    two_cycle("jr", {6'd0, 20'h7C000, 6'd8}, PCW | PS3);
    itype("addi", 6'd8, IMM);
    itype("ori", 6'd13, IMM | ZX);
    itype("andi", 6'd36, IMM | ZX);
    two_cycle("ill_funct", {6'd0, 20'h00000, 6'd1}, ILL);

    // Three jumps bring the 4-bit retire count from 13 through wrap to 0.
    for (int i = 0; i < 3; i++) two_cycle("j", {6'd2, 26'h0000100}, PCW | PS2);
    fetch("after_wrap", 32'h012A4020);
    step("after_wrap_decode", NONE, 1'b0, 1'b0);
    step("after_wrap_exec", NONE, 1'b0, 1'b0);
    step("after_wrap_wb", RGW | RD1, 1'b0, 1'b0);
    ret++;

    two_cycle("ill_op", {6'h3E, 26'h0}, ILL);

    // Reset in the middle of a stalled SW.
    fetch("sw_rst", {6'd43, 26'h0000008});
    step("sw_rst_decode", NONE, 1'b0, 1'b0);
    step("sw_rst_exec", IMM, 1'b0, 1'b0);
    step("sw_rst_mem", MRQ | MWE | IMM, 1'b0, 1'b0);
    rst = 1'b1;
    ret = '0;
    step("sw_rst_during", NONE, 1'b0, 1'b0);
    rst = 1'b0;
    fetch("sw2", {6'd43, 26'h0000008});
    step("sw2_decode", NONE, 1'b0, 1'b0);
    step("sw2_exec", IMM, 1'b0, 1'b0);
    step("sw2_mem_wait", MRQ | MWE | IMM, 1'b0, 1'b0);
    step("sw2_mem_wait", MRQ | MWE | IMM, 1'b0, 1'b0);
    step("sw2_mem_ack", MRQ | MWE | IMM, 1'b1, 1'b0);
    ret++;

    // HALT: sticky, no strobes, ack ignored; only reset leaves.
    fetch("halt", {6'h3F, 26'h0});
    step("halt_decode", NONE, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) step("halt_hold", HLT, i[0], 1'b0);
    rst = 1'b1;
    ret = '0;
    step("halt_rst", NONE, 1'b0, 1'b0);
    rst = 1'b0;
    rtype("post_halt_add", 32'h012A4020, NONE);
    fetch("final", 32'h012A4020);

    done = 1'b1;
    for (int i = 0; i < 20 && !checked; i++) @(negedge clk);
    #1;
    if (!checked) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
